la_cmd_bridge: RTL

LA_CMD_BRIDGE -- requirements
Module: la_cmd_bridge

---
 rtl/la_cmd_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/la_cmd_bridge.sv
// Logic-analyzer command bridge: turns a toggle-strobed LA command word into a
// valid/ready command toward the NN core, optionally waits for a response, and reports status.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no command in flight; waiting for an enabled strobe toggle
//   ST_ISSUE | cmd_valid asserted, payload held until cmd_ready
//   ST_WAIT  | op[3] command accepted; waiting for rsp_valid or timeout
module la_cmd_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  STATUS_TAG     = 8'hAB
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic [63:0] la_data_in,
    input  logic [63:0] la_oenb,
    output logic [63:0] la_data_out,
    output logic [15:0] status_out,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_op,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0]  CODE_OK      = 4'h1;
    localparam logic [3:0]  CODE_TIMEOUT = 4'hE;
    // Counter holds the number of WAIT cycles already spent, so expiry is one short of the limit.
    localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        tog_q;
    logic [3:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rsp_q, rsp_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] status_q, status_d;
    logic        strobe;
    logic        enable;
    logic        complete;
    logic        busy;

    assign enable = la_data_in[33];
    assign strobe = (la_data_in[32] != tog_q) && !la_oenb[32] && enable;
    assign busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rsp_d    = rsp_q;
        code_d   = code_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;
        complete = 1'b0;

        if (strobe && busy) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    op_d    = la_data_in[31:28];
                    addr_d  = la_data_in[27:20];
                    data_d  = la_data_in[19:4];
                    ovr_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    if (op_q[3]) begin
                        tmo_d   = 16'd0;
                        state_d = ST_WAIT;
                    end else begin
                        code_d   = CODE_OK;
                        complete = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                // A response arriving on the expiry cycle still counts as success.
                if (rsp_valid) begin
                    rsp_d    = rsp_data;
                    code_d   = CODE_OK;
                    complete = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    code_d   = CODE_TIMEOUT;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete) begin
            done_d  = done_q + 4'd1;
            state_d = ST_IDLE;
        end
    end

    assign status_d = enable ? {STATUS_TAG, done_q, code_q} : 16'h0000;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tog_q    <= 1'b0;
            op_q     <= 4'h0;
            addr_q   <= 8'h00;
            data_q   <= 16'h0000;
            rsp_q    <= 16'h0000;
            code_q   <= 4'h0;
            done_q   <= 4'h0;
            ovr_q    <= 1'b0;
            tmo_q    <= 16'h0000;
            status_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            tog_q    <= la_data_in[32];
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rsp_q    <= rsp_d;
            code_q   <= code_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_op      = op_q;
    assign cmd_addr    = addr_q;
    assign cmd_data    = data_q;
    assign status_out  = status_q;
    assign la_data_out = {38'd0, ovr_q, busy, done_q, code_q, rsp_q};

    logic unused_la_bits;
    assign unused_la_bits = ^{la_data_in[63:34], la_data_in[3:0], la_oenb[63:33], la_oenb[31:0]};

endmodule
